// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// Define ALU_ARBITER_FIXED_PRIO_EN to make r0 always win simultaneous requests.
module alu_arbiter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_OPS = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [3:0]       r0_opcode,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic             r0_carryin,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [3:0]       r1_opcode,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  input  logic             r1_carryin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_out,
  output logic [WIDTH-1:0] rsp_extra,
  output logic             rsp_err,
  output logic [3:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_carryin,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [WIDTH-1:0] alu_extra
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state;
  logic   grant0_c;
  logic   grant1_c;
  logic   opcode_ok_c;

`ifndef ALU_ARBITER_FIXED_PRIO_EN
  logic   prio;
`endif

  // Grant selection; only meaningful while idle.
  always_comb begin
    grant0_c = 1'b0;
    grant1_c = 1'b0;
    if (state == IDLE) begin
`ifdef ALU_ARBITER_FIXED_PRIO_EN
      grant0_c = r0_valid;
      grant1_c = r1_valid && !r0_valid;
`else
      grant0_c = r0_valid && (!r1_valid || !prio);
      grant1_c = r1_valid && (!r0_valid || prio);
`endif
    end
  end

  // Ready is forced low during reset so every output reads 0 while rst is high.
  assign r0_ready    = grant0_c && !rst;
  assign r1_ready    = grant1_c && !rst;
  assign opcode_ok_c = (32'(alu_opcode) < NUM_OPS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
`ifndef ALU_ARBITER_FIXED_PRIO_EN
      prio        <= 1'b0;
`endif
      alu_opcode  <= 4'd0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_carryin <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_out     <= '0;
      rsp_extra   <= '0;
      rsp_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0_c) begin
            alu_opcode  <= r0_opcode;
            alu_a       <= r0_a;
            alu_b       <= r0_b;
            alu_carryin <= r0_carryin;
            rsp_id      <= 1'b0;
`ifndef ALU_ARBITER_FIXED_PRIO_EN
            prio        <= 1'b1;
`endif
            state       <= EXEC;
          end else if (grant1_c) begin
            alu_opcode  <= r1_opcode;
            alu_a       <= r1_a;
            alu_b       <= r1_b;
            alu_carryin <= r1_carryin;
            rsp_id      <= 1'b1;
`ifndef ALU_ARBITER_FIXED_PRIO_EN
            prio        <= 1'b0;
`endif
            state       <= EXEC;
          end
        end
        // ALU inputs have been stable for a full cycle; capture its result.
        EXEC: begin
          if (opcode_ok_c) begin
            rsp_out   <= alu_out;
            rsp_extra <= alu_extra;
            rsp_err   <= 1'b0;
          end else begin
            rsp_out   <= '0;
            rsp_extra <= '0;
            rsp_err   <= 1'b1;
          end
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter with a stub ALU (out = a+b+cin, extra = opcode).
module tb_alu_arbiter;

  localparam int unsigned W = 32;
`ifdef ALU_ARBITER_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         r0_valid, r0_ready, r0_carryin;
  logic [3:0]   r0_opcode;
  logic [W-1:0] r0_a, r0_b;
  logic         r1_valid, r1_ready, r1_carryin;
  logic [3:0]   r1_opcode;
  logic [W-1:0] r1_a, r1_b;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [W-1:0] rsp_out, rsp_extra;
  logic [3:0]   alu_opcode;
  logic [W-1:0] alu_a, alu_b, alu_out, alu_extra;
  logic         alu_carryin;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  assign alu_out   = alu_a + alu_b + {31'b0, alu_carryin};
  assign alu_extra = {28'b0, alu_opcode};

  alu_arbiter #(.WIDTH(W), .NUM_OPS(12)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_opcode(r0_opcode),
    .r0_a(r0_a), .r0_b(r0_b), .r0_carryin(r0_carryin),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_opcode(r1_opcode),
    .r1_a(r1_a), .r1_b(r1_b), .r1_carryin(r1_carryin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_out(rsp_out), .rsp_extra(rsp_extra), .rsp_err(rsp_err),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_carryin(alu_carryin),
    .alu_out(alu_out), .alu_extra(alu_extra)
  );

  task automatic test_reset();
    rst = 1'b1;
    r0_valid = 0; r0_opcode = 0; r0_a = 0; r0_b = 0; r0_carryin = 0;
    r1_valid = 0; r1_opcode = 0; r1_a = 0; r1_b = 0; r1_carryin = 0;
    rsp_ready = 0;
    repeat (2) @(negedge clk);
    checks++; if ({r0_ready, r1_ready, rsp_valid, rsp_id, rsp_err} !== 5'b0) begin fails++; $display("FAIL reset_ctrl: got %b exp 00000", {r0_ready, r1_ready, rsp_valid, rsp_id, rsp_err}); end
    checks++; if (rsp_out !== 32'h0 || rsp_extra !== 32'h0) begin fails++; $display("FAIL reset_rsp: got %h/%h exp 0/0", rsp_out, rsp_extra); end
    checks++; if ({alu_opcode, alu_carryin} !== 5'b0 || alu_a !== 32'h0 || alu_b !== 32'h0) begin fails++; $display("FAIL reset_alu: got op %h a %h b %h cin %b exp all 0", alu_opcode, alu_a, alu_b, alu_carryin); end
    rst = 1'b0;
  endtask

  // Both requesters held valid from the first cycle after reset.
  task automatic test_round_robin();
    logic         exp_id;
    logic [W-1:0] exp_out, exp_ext;
    rsp_ready = 1;
    r0_valid = 1; r0_opcode = 4'd1; r0_a = 32'h1; r0_b = 32'h1; r0_carryin = 0;
    r1_valid = 1; r1_opcode = 4'd2; r1_a = 32'hAAAA_AAAA; r1_b = 32'h5555_5555; r1_carryin = 0;
    for (int i = 0; i < 4; i++) begin
      exp_id  = FIXED ? 1'b0 : 1'(i % 2);
      exp_out = exp_id ? 32'hFFFF_FFFF : 32'h2;
      exp_ext = exp_id ? 32'h2 : 32'h1;
      #1;
      checks++; if ({r0_ready, r1_ready} !== {~exp_id, exp_id}) begin fails++; $display("FAIL rr_ready op%0d: got %b exp %b", i, {r0_ready, r1_ready}, {~exp_id, exp_id}); end
      @(negedge clk);
      checks++; if ({r0_ready, r1_ready, rsp_valid} !== 3'b0) begin fails++; $display("FAIL rr_exec op%0d: got %b exp 000", i, {r0_ready, r1_ready, rsp_valid}); end
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== exp_id) begin fails++; $display("FAIL rr_rsp op%0d: valid %b id %b exp 1/%b", i, rsp_valid, rsp_id, exp_id); end
      checks++; if (rsp_out !== exp_out || rsp_extra !== exp_ext || rsp_err !== 1'b0) begin fails++; $display("FAIL rr_data op%0d: got %h/%h/%b exp %h/%h/0", i, rsp_out, rsp_extra, rsp_err, exp_out, exp_ext); end
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rr_drop op%0d: got %b exp 0", i, rsp_valid); end
    end
    r0_valid = 0; r1_valid = 0;
  endtask

  task automatic test_single_r0();
    r0_valid = 1; r0_opcode = 4'd3; r0_a = 32'h5; r0_b = 32'h7; r0_carryin = 1;
    #1;
    checks++; if ({r0_ready, r1_ready} !== 2'b10) begin fails++; $display("FAIL single_ready: got %b exp 10", {r0_ready, r1_ready}); end
    @(negedge clk);
    r0_valid = 0;
    checks++; if (r0_ready !== 1'b0 || rsp_valid !== 1'b0 || alu_a !== 32'h5 || alu_b !== 32'h7 || alu_opcode !== 4'd3) begin fails++; $display("FAIL single_exec: ready %b valid %b a %h b %h op %h", r0_ready, rsp_valid, alu_a, alu_b, alu_opcode); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin fails++; $display("FAIL single_rsp: valid %b id %b err %b exp 1/0/0", rsp_valid, rsp_id, rsp_err); end
    checks++; if (rsp_out !== 32'hD || rsp_extra !== 32'h3) begin fails++; $display("FAIL single_data: got %h/%h exp 0000000d/00000003", rsp_out, rsp_extra); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || alu_a !== 32'h5) begin fails++; $display("FAIL single_after: valid %b alu_a %h exp 0/5", rsp_valid, alu_a); end
  endtask

  task automatic test_illegal_op();
    r1_valid = 1; r1_opcode = 4'd13; r1_a = 32'h1; r1_b = 32'h2; r1_carryin = 0;
    #1;
    checks++; if ({r0_ready, r1_ready} !== 2'b01) begin fails++; $display("FAIL illegal_ready: got %b exp 01", {r0_ready, r1_ready}); end
    @(negedge clk);
    r1_valid = 0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_err !== 1'b1) begin fails++; $display("FAIL illegal_rsp: valid %b id %b err %b exp 1/1/1", rsp_valid, rsp_id, rsp_err); end
    checks++; if (rsp_out !== 32'h0 || rsp_extra !== 32'h0) begin fails++; $display("FAIL illegal_data: got %h/%h exp 0/0", rsp_out, rsp_extra); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    rsp_ready = 0;
    r0_valid = 1; r0_opcode = 4'd0; r0_a = 32'h10; r0_b = 32'h20; r0_carryin = 0;
    @(negedge clk);
    r0_valid = 0;
    r1_valid = 1; r1_opcode = 4'd5; r1_a = 32'd100; r1_b = 32'd200; r1_carryin = 1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_out !== 32'h30 || rsp_extra !== 32'h0 || rsp_err !== 1'b0) begin fails++; $display("FAIL bp_hold cyc%0d: valid %b id %b out %h ext %h err %b exp 1/0/30/0/0", i, rsp_valid, rsp_id, rsp_out, rsp_extra, rsp_err); end
      checks++; if ({r0_ready, r1_ready} !== 2'b00) begin fails++; $display("FAIL bp_ready cyc%0d: got %b exp 00", i, {r0_ready, r1_ready}); end
      if (i < 4) @(negedge clk);
    end
    rsp_ready = 1;
    @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b0 || {r0_ready, r1_ready} !== 2'b01) begin fails++; $display("FAIL bp_release: valid %b ready %b exp 0/01", rsp_valid, {r0_ready, r1_ready}); end
    @(negedge clk);
    r1_valid = 0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_out !== 32'd301 || rsp_extra !== 32'h5) begin fails++; $display("FAIL bp_next: valid %b id %b out %h ext %h exp 1/1/12d/5", rsp_valid, rsp_id, rsp_out, rsp_extra); end
    @(negedge clk);
  endtask

  // Reset in EXEC with r0 having just been granted (prio would otherwise favour r1).
  task automatic test_reset_mid_exec();
    rsp_ready = 1;
    r0_valid = 1; r0_opcode = 4'd2; r0_a = 32'h3; r0_b = 32'h4; r0_carryin = 0;
    @(negedge clk);
    r1_valid = 1; r1_opcode = 4'd1; r1_a = 32'h1; r1_b = 32'h1; r1_carryin = 0;
    rst = 1;
    #1;
    checks++; if ({r0_ready, r1_ready, rsp_valid, rsp_id, rsp_err, alu_carryin} !== 6'b0 || alu_opcode !== 4'd0) begin fails++; $display("FAIL rstx_ctrl: got %b op %h exp 0", {r0_ready, r1_ready, rsp_valid, rsp_id, rsp_err, alu_carryin}, alu_opcode); end
    checks++; if (alu_a !== 32'h0 || alu_b !== 32'h0 || rsp_out !== 32'h0 || rsp_extra !== 32'h0) begin fails++; $display("FAIL rstx_data: a %h b %h out %h ext %h exp 0", alu_a, alu_b, rsp_out, rsp_extra); end
    r0_valid = 0; r1_valid = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rstx_norsp: got %b exp 0", rsp_valid); end
    r0_valid = 1; r0_opcode = 4'd7; r0_a = 32'h8; r0_b = 32'h9; r0_carryin = 1;
    r1_valid = 1;
    #1;
    checks++; if ({r0_ready, r1_ready} !== 2'b10) begin fails++; $display("FAIL rstx_prio: got %b exp 10", {r0_ready, r1_ready}); end
    @(negedge clk);
    r0_valid = 0; r1_valid = 0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_out !== 32'h12 || rsp_extra !== 32'h7) begin fails++; $display("FAIL rstx_serve: valid %b id %b out %h ext %h exp 1/0/12/7", rsp_valid, rsp_id, rsp_out, rsp_extra); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_r0();
    test_illegal_op();
    test_backpressure();
    test_reset_mid_exec();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
